// File: rtl/cell_bin_bank_sched_if.sv
// rtl/cell_bin_bank_sched_if.sv - requester, bank B-port and frame status bundle for cell_bin_bank_sched
interface cell_bin_bank_sched_if #(
    parameter int ADDR_WIDTH      = 13,
    parameter int TOTAL_BIT_WIDTH = 35
);
    logic                                  frame_start;
    logic                                  hist_done;
    logic                                  norm_done;
    logic [3:0]                            hist_en;
    logic [3:0]                            hist_we;
    logic [3:0][ADDR_WIDTH-1:0]            hist_addr;
    logic [3:0][TOTAL_BIT_WIDTH-1:0]       hist_din;
    logic [3:0]                            norm_en;
    logic [3:0][ADDR_WIDTH-1:0]            norm_addr;
    logic [3:0]                            bport_en;
    logic [3:0]                            bport_we;
    logic [3:0][ADDR_WIDTH-1:0]            bport_addr;
    logic [3:0][TOTAL_BIT_WIDTH-1:0]       bport_din;
    logic                                  hist_grant;
    logic                                  norm_grant;
    logic                                  frame_busy;
    logic                                  frame_done;
    logic [15:0]                           conflict_cnt;

    modport master (
        output frame_start, hist_done, norm_done,
        output hist_en, hist_we, hist_addr, hist_din,
        output norm_en, norm_addr,
        input  bport_en, bport_we, bport_addr, bport_din,
        input  hist_grant, norm_grant, frame_busy, frame_done, conflict_cnt
    );

    modport slave (
        input  frame_start, hist_done, norm_done,
        input  hist_en, hist_we, hist_addr, hist_din,
        input  norm_en, norm_addr,
        output bport_en, bport_we, bport_addr, bport_din,
        output hist_grant, norm_grant, frame_busy, frame_done, conflict_cnt
    );
endinterface

// File: rtl/cell_bin_bank_sched.sv
// rtl/cell_bin_bank_sched.sv - frame scheduler (clear/accum/norm) owning the four cell-bin bank B ports
// Optional dropped-request counter enabled by BANK_CONFLICT_CNT_EN.
module cell_bin_bank_sched #(
    parameter int TOTAL_BIT_WIDTH = 35,
    parameter int ADDR_WIDTH      = 13,
    parameter int BANK_DEPTH      = 5202
) (
    input  logic                  aclk,
    input  logic                  arest_n,
    cell_bin_bank_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_NORM  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(BANK_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] CLR_ONE  = ADDR_WIDTH'(1);

    state_t                              state_q;
    logic [ADDR_WIDTH-1:0]               clr_cnt_q;
    logic [3:0]                          en_q;
    logic [3:0]                          we_q;
    logic [3:0][ADDR_WIDTH-1:0]          addr_q;
    logic [3:0][TOTAL_BIT_WIDTH-1:0]     din_q;
    logic                                done_q;
    logic [ADDR_WIDTH-1:0]               clr_nxt;

    assign clr_nxt = clr_cnt_q + CLR_ONE;

    // Clear writes are issued one address ahead of clr_cnt so the first zero-write
    // appears the cycle right after frame_start and the phase lasts BANK_DEPTH cycles.
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            en_q      <= '0;
            we_q      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            en_q   <= '0;
            we_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                        en_q      <= '1;
                        we_q      <= '1;
                        addr_q    <= '0;
                        din_q     <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q   <= ST_ACCUM;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_nxt;
                        en_q      <= '1;
                        we_q      <= '1;
                        for (int i = 0; i < 4; i++) addr_q[i] <= clr_nxt;
                        din_q     <= '0;
                    end
                end
                ST_ACCUM: begin
                    en_q   <= bus.hist_en;
                    we_q   <= bus.hist_we;
                    addr_q <= bus.hist_addr;
                    din_q  <= bus.hist_din;
                    if (bus.hist_done) state_q <= ST_NORM;
                end
                ST_NORM: begin
                    en_q   <= bus.norm_en;
                    addr_q <= bus.norm_addr;
                    din_q  <= '0;
                    if (bus.norm_done) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.bport_en   = en_q;
    assign bus.bport_we   = we_q;
    assign bus.bport_addr = addr_q;
    assign bus.bport_din  = din_q;
    assign bus.hist_grant = (state_q == ST_ACCUM);
    assign bus.norm_grant = (state_q == ST_NORM);
    assign bus.frame_busy = (state_q != ST_IDLE);
    assign bus.frame_done = done_q;

`ifdef BANK_CONFLICT_CNT_EN
    logic        drop_evt;
    logic [15:0] conflict_q;

    assign drop_evt = ((state_q != ST_ACCUM) && (bus.hist_en != 4'd0)) ||
                      ((state_q != ST_NORM)  && (bus.norm_en != 4'd0));

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            conflict_q <= '0;
        end else if ((state_q == ST_IDLE) && bus.frame_start) begin
            conflict_q <= '0;
        end else if (drop_evt && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign bus.conflict_cnt = conflict_q;
`else
    assign bus.conflict_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_cell_bin_bank_sched.sv
// tb/tb_cell_bin_bank_sched.sv - directed and randomized checks of cell_bin_bank_sched against a phase model
module tb_cell_bin_bank_sched;
    localparam int AW    = 13;
    localparam int DW    = 35;
    localparam int DEPTH = 8;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_ACCUM = 2;
    localparam int P_NORM  = 3;

    logic aclk;
    logic arest_n;

    cell_bin_bank_sched_if #(.ADDR_WIDTH(AW), .TOTAL_BIT_WIDTH(DW)) bus ();

    cell_bin_bank_sched #(
        .TOTAL_BIT_WIDTH(DW),
        .ADDR_WIDTH     (AW),
        .BANK_DEPTH     (DEPTH)
    ) dut (
        .aclk   (aclk),
        .arest_n(arest_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.frame_start = 1'b0;
        bus.hist_done   = 1'b0;
        bus.norm_done   = 1'b0;
        bus.hist_en     = '0;
        bus.hist_we     = '0;
        bus.hist_addr   = '0;
        bus.hist_din    = '0;
        bus.norm_en     = '0;
        bus.norm_addr   = '0;
    endtask

    // Phase model: phase of each cycle, index within the clear, and what the
    // bank ports must show given the phase and requests of the previous cycle.
    int                      m_phase;
    int                      m_clr;
    logic [3:0]              x_en, x_we;
    logic [3:0][AW-1:0]      x_addr;
    logic [3:0][DW-1:0]      x_din;
    logic                    x_done;
    int                      x_cnt;

    always @(posedge aclk or negedge arest_n) begin : model
        int prev;
        bit drop;
        if (!arest_n) begin
            m_phase = P_IDLE;
            m_clr   = 0;
            x_en    = '0;
            x_we    = '0;
            x_addr  = '0;
            x_din   = '0;
            x_done  = 1'b0;
            x_cnt   = 0;
        end else begin
            prev = m_phase;
            drop = ((prev != P_ACCUM) && (bus.hist_en != 0)) ||
                   ((prev != P_NORM)  && (bus.norm_en != 0));
            case (prev)
                P_IDLE:  if (bus.frame_start) begin m_phase = P_CLEAR; m_clr = 0; end
                P_CLEAR: begin m_clr++; if (m_clr == DEPTH) m_phase = P_ACCUM; end
                P_ACCUM: if (bus.hist_done) m_phase = P_NORM;
                default: if (bus.norm_done) m_phase = P_IDLE;
            endcase
            x_done = (prev == P_NORM) && bus.norm_done;
            if (m_phase == P_CLEAR) begin
                x_en = '1;
                x_we = '1;
                for (int i = 0; i < 4; i++) x_addr[i] = AW'(m_clr);
                x_din = '0;
            end else if (prev == P_ACCUM) begin
                x_en   = bus.hist_en;
                x_we   = bus.hist_we;
                x_addr = bus.hist_addr;
                x_din  = bus.hist_din;
            end else if (prev == P_NORM) begin
                x_en   = bus.norm_en;
                x_we   = '0;
                x_addr = bus.norm_addr;
                x_din  = '0;
            end else begin
                x_en = '0;
                x_we = '0;
            end
            if ((prev == P_IDLE) && bus.frame_start) x_cnt = 0;
            else if (drop && (x_cnt < 65535)) x_cnt++;
        end
    end

    always @(negedge aclk) begin : compare
        chk("bport_en", 64'(bus.bport_en), 64'(x_en));
        chk("bport_we", 64'(bus.bport_we), 64'(x_we));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bport_addr_%0d", i), 64'(bus.bport_addr[i]), 64'(x_addr[i]));
            chk($sformatf("bport_din_%0d", i), 64'(bus.bport_din[i]), 64'(x_din[i]));
        end
        chk("hist_grant", 64'(bus.hist_grant), 64'(m_phase == P_ACCUM));
        chk("norm_grant", 64'(bus.norm_grant), 64'(m_phase == P_NORM));
        chk("frame_busy", 64'(bus.frame_busy), 64'(m_phase != P_IDLE));
        chk("frame_done", 64'(bus.frame_done), 64'(x_done));
`ifdef BANK_CONFLICT_CNT_EN
        chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(x_cnt));
`else
        chk("conflict_cnt", 64'(bus.conflict_cnt), 64'd0);
`endif
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] exp_cnt3;
`ifdef BANK_CONFLICT_CNT_EN
        exp_cnt3 = 16'd3;
`else
        exp_cnt3 = 16'd0;
`endif
        arest_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_bport_en", 64'(bus.bport_en), 64'd0);
        chk("rst_frame_busy", 64'(bus.frame_busy), 64'd0);
        chk("rst_conflict_cnt", 64'(bus.conflict_cnt), 64'd0);
        @(posedge aclk);
        #1 arest_n = 1'b1;
        tick();

        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge aclk);
            chk("clr_addr_3", 64'(bus.bport_addr[3]), 64'(k));
            chk("clr_we", 64'(bus.bport_we), 64'hF);
            if (k < DEPTH - 1) tick();
        end
        tick();
        @(negedge aclk);
        chk("accum_hist_grant", 64'(bus.hist_grant), 64'd1);
        chk("accum_first_en", 64'(bus.bport_en), 64'd0);

        bus.hist_en      = 4'b0100;
        bus.hist_we      = 4'b0100;
        bus.hist_addr[2] = 13'd100;
        bus.hist_din[2]  = 35'd5;
        tick();
        clear_inputs();
        @(negedge aclk);
        chk("hist_en_fwd", 64'(bus.bport_en), 64'b0100);
        chk("hist_addr_2", 64'(bus.bport_addr[2]), 64'd100);
        chk("hist_din_2", 64'(bus.bport_din[2]), 64'd5);

        bus.norm_en = 4'b0001;
        repeat (3) tick();
        clear_inputs();
        @(negedge aclk);
        chk("drop_no_en", 64'(bus.bport_en), 64'd0);
        chk("drop_cnt3", 64'(bus.conflict_cnt), 64'(exp_cnt3));

        bus.hist_done = 1'b1;
        tick();
        bus.hist_done = 1'b0;
        bus.norm_en      = 4'b0010;
        bus.norm_addr[1] = 13'd306;
        tick();
        clear_inputs();
        @(negedge aclk);
        chk("norm_en_fwd", 64'(bus.bport_en), 64'b0010);
        chk("norm_we", 64'(bus.bport_we), 64'd0);
        chk("norm_addr_1", 64'(bus.bport_addr[1]), 64'd306);
        chk("norm_grant", 64'(bus.norm_grant), 64'd1);
        chk("norm_hist_grant", 64'(bus.hist_grant), 64'd0);

        bus.norm_done   = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        clear_inputs();
        @(negedge aclk);
        chk("done_pulse", 64'(bus.frame_done), 64'd1);
        chk("done_idle", 64'(bus.frame_busy), 64'd0);
        tick();
        @(negedge aclk);
        chk("done_once", 64'(bus.frame_done), 64'd0);
        chk("no_clear_busy", 64'(bus.frame_busy), 64'd0);
        chk("no_clear_we", 64'(bus.bport_we), 64'd0);

        bus.frame_start = 1'b1;
        tick();
        clear_inputs();
        @(negedge aclk);
        chk("start_cnt_clr", 64'(bus.conflict_cnt), 64'd0);
        chk("start_addr_0", 64'(bus.bport_addr[0]), 64'd0);
        repeat (4) tick();
        arest_n = 1'b0;
        #1;
        chk("arst_en", 64'(bus.bport_en), 64'd0);
        chk("arst_busy", 64'(bus.frame_busy), 64'd0);
        @(posedge aclk);
        #1 arest_n = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        clear_inputs();
        @(negedge aclk);
        chk("restart_addr_0", 64'(bus.bport_addr[0]), 64'd0);
        chk("restart_we", 64'(bus.bport_we), 64'hF);

        for (int c = 0; c < 4000; c++) begin
            bus.frame_start = ($urandom_range(0, 5) == 0);
            bus.hist_done   = ($urandom_range(0, 24) == 0);
            bus.norm_done   = ($urandom_range(0, 24) == 0);
            bus.hist_en     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            bus.hist_we     = 4'($urandom_range(0, 15));
            bus.norm_en     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            for (int i = 0; i < 4; i++) begin
                bus.hist_addr[i] = AW'($urandom);
                bus.norm_addr[i] = AW'($urandom);
                bus.hist_din[i]  = DW'({$urandom, $urandom});
            end
            if (c == 2000) arest_n = 1'b0;
            tick();
            if (c == 2000) arest_n = 1'b1;
        end
        clear_inputs();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
